// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its midpoint and
// holds the received byte behind a valid/ack handshake with framing/overrun flags.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | counting to mid start bit to confirm it is still low
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | waiting for mid stop bit; high accepts the byte, low is a framing error
// BREAK | stop bit was low, waiting for the line to return high
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_m;
    logic          rx_s;
    logic          stop_done;
    logic          accept;

    // Both synchroniser flops reset high so a reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign stop_done = (state == STOP) && (cnt == BIT_LAST);
    assign accept    = stop_done && rx_s;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // An ack coinciding with a completed byte frees the register for it.
            if (accept && (!valid || ack)) begin
                data    <= shift;
                valid   <= 1'b1;
                overrun <= 1'b0;
            end else if (accept) begin
                overrun <= 1'b1;
            end else if (ack && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (stop_done && !rx_s) frame_err <= 1'b1;
        end
    end

endmodule
